// File: rtl/semaforo_pkg.sv
// Shared light encodings and helpers for the traffic-light monitor.
package semaforo_pkg;

  localparam logic [2:0] VERDE_C    = 3'b100;
  localparam logic [2:0] AMARELO_C  = 3'b010;
  localparam logic [2:0] VERMELHO_C = 3'b001;

  typedef enum logic {
    UNSYNC,
    TRACK
  } trk_state_e;

  function automatic logic [2:0] proximo_cor(input logic [2:0] cor);
    case (cor)
      VERDE_C:    return AMARELO_C;
      AMARELO_C:  return VERMELHO_C;
      VERMELHO_C: return VERDE_C;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [2:0] v);
    return (v == VERDE_C) || (v == AMARELO_C) || (v == VERMELHO_C);
  endfunction

endpackage

// File: rtl/light_seq_checker.sv
// Checks one registered light stream: one-hot, colour order and (optionally) phase durations.
// Flags are combinational from the current sample vs the previous one; the parent registers them.
module light_seq_checker
  import semaforo_pkg::*;
#(
  parameter bit CHECK_TIME = 1'b1,
  parameter int T_VERDE    = 10,
  parameter int T_AMARELO  = 3,
  parameter int T_VERMELHO = 8,
  parameter int CW         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       smp_vld_i,
  input  logic [2:0] cor_i,
  output logic       err_onehot_o,
  output logic       err_order_o,
  output logic       err_dur_o,
  output logic       ciclo_o,
  output logic       sync_o
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  trk_state_e    state_q, state_d;
  logic [2:0]    prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovr_q, ovr_d;
  logic [CW:0]   req;
  logic          cur_oh, prev_oh, chg, succ_ok, legal_chg, in_track;

  always_comb begin
    case (prev_q)
      VERDE_C:    req = (CW+1)'(T_VERDE);
      AMARELO_C:  req = (CW+1)'(T_AMARELO);
      VERMELHO_C: req = (CW+1)'(T_VERMELHO);
      default:    req = '0;
    endcase
  end

  always_comb begin
    cur_oh    = is_onehot(cor_i);
    prev_oh   = is_onehot(prev_q);
    chg       = (cor_i != prev_q);
    succ_ok   = (cor_i == proximo_cor(prev_q));
    in_track  = (state_q == TRACK);
    legal_chg = cur_oh && prev_oh && chg && succ_ok;

    state_d      = state_q;
    cnt_d        = cnt_q;
    ovr_d        = ovr_q;
    err_onehot_o = 1'b0;
    err_order_o  = 1'b0;
    err_dur_o    = 1'b0;
    ciclo_o      = 1'b0;

    if (smp_vld_i) begin
      if (chg) begin
        cnt_d = CW'(1);
        ovr_d = 1'b0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end

      err_onehot_o = !cur_oh;
      if (cur_oh) begin
        err_order_o = (chg && prev_oh && !succ_ok) || (!prev_oh && in_track);
        // An overrun already reported this phase, so the closing change stays quiet.
        if (CHECK_TIME && in_track && !ovr_q) begin
          if (chg) begin
            err_dur_o = ({1'b0, cnt_q} != req);
          end else if ({1'b0, cnt_d} == req + 1'b1) begin
            err_dur_o = 1'b1;
            ovr_d     = 1'b1;
          end
        end
      end

      if (err_onehot_o || err_order_o) begin
        state_d = UNSYNC;
      end else if (!in_track && legal_chg) begin
        state_d = TRACK;
      end

      ciclo_o = in_track && legal_chg && (prev_q == VERMELHO_C);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNSYNC;
      prev_q  <= 3'b000;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else if (smp_vld_i) begin
      state_q <= state_d;
      prev_q  <= cor_i;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sync_o = (state_q == TRACK);

endmodule

// File: rtl/semaforo_monitor.sv
// Passive monitor for the A/B traffic lights; flags appear 2 edges after the offending input.
// Never drives the lights and applies no backpressure.
module semaforo_monitor
  import semaforo_pkg::*;
#(
  parameter int T_VERDE    = 10,
  parameter int T_AMARELO  = 3,
  parameter int T_VERMELHO = 8,
  parameter int CW         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  A,
  input  logic [2:0]  B,
  output logic [4:0]  err_pulse,
  output logic [4:0]  err_sticky,
  output logic [15:0] ciclos,
  output logic        sync_a
);

  logic [2:0]  a_q, b_q;
  logic        smp_vld_q;
  logic [4:0]  err_pulse_q, err_pulse_d;
  logic [4:0]  err_sticky_q, err_sticky_d;
  logic [15:0] ciclos_q, ciclos_d;

  logic a_oh, a_ord, a_dur, a_ciclo, a_sync;
  logic b_oh, b_ord, b_dur_unused, b_ciclo_unused, b_sync_unused;

  light_seq_checker #(
    .CHECK_TIME (1'b1),
    .T_VERDE    (T_VERDE),
    .T_AMARELO  (T_AMARELO),
    .T_VERMELHO (T_VERMELHO),
    .CW         (CW)
  ) u_chk_a (
    .clk          (clk),
    .rst          (rst),
    .smp_vld_i    (smp_vld_q),
    .cor_i        (a_q),
    .err_onehot_o (a_oh),
    .err_order_o  (a_ord),
    .err_dur_o    (a_dur),
    .ciclo_o      (a_ciclo),
    .sync_o       (a_sync)
  );

  // B follows A on request and may hold any colour, so only encoding and order are checked.
  light_seq_checker #(
    .CHECK_TIME (1'b0),
    .T_VERDE    (T_VERDE),
    .T_AMARELO  (T_AMARELO),
    .T_VERMELHO (T_VERMELHO),
    .CW         (CW)
  ) u_chk_b (
    .clk          (clk),
    .rst          (rst),
    .smp_vld_i    (smp_vld_q),
    .cor_i        (b_q),
    .err_onehot_o (b_oh),
    .err_order_o  (b_ord),
    .err_dur_o    (b_dur_unused),
    .ciclo_o      (b_ciclo_unused),
    .sync_o       (b_sync_unused)
  );

  always_comb begin
    err_pulse_d  = {b_ord, b_oh, a_dur, a_ord, a_oh};
    err_sticky_d = err_sticky_q | err_pulse_d;
    ciclos_d     = ciclos_q + {15'd0, a_ciclo};
  end

  // smp_vld_q masks the reset value of the input registers from being checked as a sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= 3'b000;
      b_q          <= 3'b000;
      smp_vld_q    <= 1'b0;
      err_pulse_q  <= '0;
      err_sticky_q <= '0;
      ciclos_q     <= '0;
    end else begin
      a_q          <= A;
      b_q          <= B;
      smp_vld_q    <= 1'b1;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      ciclos_q     <= ciclos_d;
    end
  end

  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign ciclos     = ciclos_q;
  assign sync_a     = a_sync;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed bench for semaforo_monitor: nominal cycles, overrun, illegal order, B encoding, reset, wrap.
module tb_semaforo_monitor;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;

  logic        clk;
  logic        rst, rst2;
  logic [2:0]  A, B, A2, B2;
  logic [4:0]  err_pulse, err_sticky, err_pulse2, err_sticky2;
  logic [15:0] ciclos, ciclos2;
  logic        sync_a, sync_a2;

  int n_chk  = 0;
  int n_fail = 0;
  int pc[5];

  semaforo_monitor u_dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .ciclos     (ciclos),
    .sync_a     (sync_a)
  );

  semaforo_monitor #(
    .T_VERDE    (1),
    .T_AMARELO  (1),
    .T_VERMELHO (1)
  ) u_wrap (
    .clk        (clk),
    .rst        (rst2),
    .A          (A2),
    .B          (B2),
    .err_pulse  (err_pulse2),
    .err_sticky (err_sticky2),
    .ciclos     (ciclos2),
    .sync_a     (sync_a2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 5; i++) begin
      if (err_pulse[i]) pc[i]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [2:0] a, input logic [2:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      A = a;
      B = b;
      @(negedge clk);
    end
  endtask

  task automatic drv2(input logic [2:0] a);
    A2 = a;
    @(negedge clk);
  endtask

  task automatic nominal_cycle();
    hold(G, R, 10);
    hold(Y, R, 3);
    hold(R, G, 5);
    hold(R, Y, 3);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) pc[i] = 0;
    rst = 1'b1; rst2 = 1'b1;
    A = 3'b000; B = 3'b000; A2 = R; B2 = R;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pulse",  32'(err_pulse),  32'h0);
    chk("rst_sticky", 32'(err_sticky), 32'h0);
    chk("rst_ciclos", 32'(ciclos),     32'h0);
    chk("rst_sync",   32'(sync_a),     32'h0);
    rst = 1'b0;

    // Nominal: first green is partial and unchecked; tracking arms at green->yellow.
    hold(G, R, 10);
    chk("sync_before_change", 32'(sync_a), 32'h0);
    hold(Y, R, 3);
    hold(R, G, 5);
    hold(R, Y, 3);
    chk("sync_after_change", 32'(sync_a), 32'h1);
    nominal_cycle();
    nominal_cycle();
    hold(G, R, 1);
    chk("nom_sticky", 32'(err_sticky), 32'h0);
    chk("nom_ciclos", 32'(ciclos),     32'h2);
    chk("nom_sync",   32'(sync_a),     32'h1);

    // Green held 11 samples: one overrun pulse, silent change to yellow.
    hold(G, R, 10);
    hold(Y, R, 1);
    chk("ovr_pulse", 32'(err_pulse), 32'h04);
    hold(Y, R, 1);
    chk("ovr_no_second", 32'(err_pulse), 32'h00);
    hold(Y, R, 1);
    hold(R, G, 5);
    hold(R, Y, 3);
    chk("ovr_sticky", 32'(err_sticky), 32'h04);
    chk("ovr_ciclos", 32'(ciclos),     32'h3);

    // Green -> red directly.
    hold(G, R, 10);
    hold(R, R, 1);
    hold(R, R, 1);
    chk("ill_pulse", 32'(err_pulse), 32'h02);
    chk("ill_sync",  32'(sync_a),    32'h0);
    hold(R, R, 3);
    hold(G, R, 1);
    hold(G, R, 1);
    chk("resync",        32'(sync_a), 32'h1);
    chk("resync_ciclos", 32'(ciclos), 32'h4);
    hold(G, R, 8);
    hold(Y, R, 3);
    hold(R, G, 1);
    chk("resync_sticky", 32'(err_sticky), 32'h06);
    chk("dur_pulses",    32'(pc[2]),      32'h1);
    chk("order_pulses",  32'(pc[1]),      32'h1);

    // B not one-hot for a single sample.
    hold(R, 3'b110, 1);
    hold(R, G, 1);
    chk("b_onehot_pulse", 32'(err_pulse), 32'h08);
    hold(R, G, 3);
    hold(R, Y, 3);
    hold(G, R, 10);
    hold(Y, R, 2);
    chk("pre_rst_ciclos", 32'(ciclos),     32'h5);
    chk("pre_rst_sticky", 32'(err_sticky), 32'h0E);
    chk("pre_rst_sync",   32'(sync_a),     32'h1);
    chk("b_order_pulses", 32'(pc[4]),      32'h0);

    // Reset mid-yellow.
    rst = 1'b1;
    hold(Y, R, 1);
    chk("mid_rst_sticky", 32'(err_sticky), 32'h0);
    chk("mid_rst_ciclos", 32'(ciclos),     32'h0);
    chk("mid_rst_sync",   32'(sync_a),     32'h0);
    chk("mid_rst_pulse",  32'(err_pulse),  32'h0);
    rst = 1'b0;
    hold(Y, R, 4);
    chk("post_rst_sticky", 32'(err_sticky), 32'h0);
    chk("post_rst_sync",   32'(sync_a),     32'h0);

    // Wrap of ciclos on the 1/1/1 instance.
    rst2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drv2(G);
      drv2(Y);
      drv2(R);
    end
    drv2(G);
    drv2(Y);
    force u_wrap.ciclos_q = 16'hFFFE;
    drv2(R);
    release u_wrap.ciclos_q;
    drv2(G);
    drv2(Y);
    chk("wrap_ffff", 32'(ciclos2), 32'hFFFF);
    drv2(R);
    drv2(G);
    drv2(Y);
    chk("wrap_zero",   32'(ciclos2),     32'h0);
    chk("wrap_sticky", 32'(err_sticky2), 32'h0);
    chk("wrap_sync",   32'(sync_a2),     32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
